// File: rtl/multdiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
//   - FSM state encoding (2 bits, legacy-compatible localparams)
//   - ALU opcode constants for the multiply/divide instructions, so the
//     decoder and this unit agree on a single definition
package multdiv_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [4:0] OP_MULT = 5'b00110;
  localparam logic [4:0] OP_DIV  = 5'b00111;

endpackage

// File: rtl/multdiv_signfix.sv
// Conditional two's-complement negation.
// Used both to turn signed operands into magnitudes and to re-apply the
// result sign to a magnitude result.
//   value  : input word
//   negate : 1 -> result = -value, 0 -> result = value
//   result : output word (same width)
module multdiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/multdiv_seq.sv
// Sequential signed multiply/divide unit (one bit per cycle).
//   clock / reset_n      : clock, asynchronous active-low reset
//   data_operandA/B      : signed operands, sampled only on the start cycle
//   ctrl_MULT / ctrl_DIV : start pulses (both high together is ignored)
//   data_result          : low WIDTH bits of product / truncated quotient
//   data_exception       : overflow or divide-by-zero
//   data_resultRDY       : one-cycle pulse, result/exception valid that cycle
//   busy                 : operation in flight
//   state_dbg            : current FSM state (multdiv_pkg ST_* encoding)
//
// Handshake: a start is one cycle with exactly one of ctrl_MULT/ctrl_DIV
// high; it is always accepted (aborting any operation in flight) and the
// matching data_resultRDY pulse arrives WIDTH edges after the start edge,
// with no back-pressure. An aborted operation never produces a pulse.
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             sign_q;
  logic             div_zero_q;
  // MUL: opnd = |multiplicand|, acc_hi:acc_lo = partial product : multiplier
  // DIV: opnd = |divisor|,      acc_hi:acc_lo = remainder : dividend/quotient
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic start_mul;
  logic start_div;
  assign start_mul = ctrl_MULT & ~ctrl_DIV;
  assign start_div = ctrl_DIV & ~ctrl_MULT;

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1),
  // which still fits as an unsigned WIDTH-bit number.
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  multdiv_signfix #(.WIDTH(WIDTH)) u_fix_a (
    .value (data_operandA),
    .negate(data_operandA[WIDTH-1]),
    .result(a_mag)
  );
  multdiv_signfix #(.WIDTH(WIDTH)) u_fix_b (
    .value (data_operandB),
    .negate(data_operandB[WIDTH-1]),
    .result(b_mag)
  );

  // Shift-add multiply step.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n;
  logic [WIDTH-1:0] mul_lo_n;
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign mul_hi_n = mul_sum[WIDTH:1];
  assign mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};

  // Restoring shift-subtract divide step. The remainder stays below the
  // divisor (<= 2^(WIDTH-1)), so dropping acc_hi's MSB on the shift is safe.
  logic [WIDTH-1:0] div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] div_hi_n;
  logic [WIDTH-1:0] div_lo_n;
  assign div_shift = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
  assign div_trial = {1'b0, div_shift} - {1'b0, opnd};
  assign div_hi_n  = div_trial[WIDTH] ? div_shift : div_trial[WIDTH-1:0];
  assign div_lo_n  = {acc_lo[WIDTH-2:0], ~div_trial[WIDTH]};

  // Final sign correction, done at double width so the MUL overflow test
  // sees the full signed product. The quotient is zero-extended.
  logic [2*WIDTH-1:0] raw_res;
  logic [2*WIDTH-1:0] fixed_res;
  assign raw_res = (state == ST_MUL) ? {mul_hi_n, mul_lo_n}
                                     : {{WIDTH{1'b0}}, div_lo_n};
  multdiv_signfix #(.WIDTH(2 * WIDTH)) u_fix_res (
    .value (raw_res),
    .negate(sign_q),
    .result(fixed_res)
  );

  logic             mul_ovf;
  logic             div_ovf;
  logic [WIDTH-1:0] res_n;
  logic             exc_n;
  // Representable iff the top WIDTH+1 bits are all equal.
  assign mul_ovf = ~((&fixed_res[2*WIDTH-1:WIDTH-1]) |
                     ~(|fixed_res[2*WIDTH-1:WIDTH-1]));
  // Only a positive quotient of magnitude 2^(WIDTH-1) overflows (MIN / -1).
  assign div_ovf = ~sign_q & div_lo_n[WIDTH-1];

  always_comb begin
    res_n = fixed_res[WIDTH-1:0];
    exc_n = mul_ovf;
    if (state == ST_DIV) begin
      res_n = div_zero_q ? '0 : fixed_res[WIDTH-1:0];
      exc_n = div_zero_q | div_ovf;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      sign_q         <= 1'b0;
      div_zero_q     <= 1'b0;
      opnd           <= '0;
      acc_hi         <= '0;
      acc_lo         <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start_mul || start_div) begin
        // A start always wins, including over the last iteration step.
        state      <= start_mul ? ST_MUL : ST_DIV;
        cnt        <= '0;
        sign_q     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        div_zero_q <= start_div && (data_operandB == '0);
        opnd       <= start_mul ? a_mag : b_mag;
        acc_hi     <= '0;
        acc_lo     <= start_mul ? b_mag : a_mag;
      end else begin
        case (state)
          ST_MUL, ST_DIV: begin
            acc_hi <= (state == ST_MUL) ? mul_hi_n : div_hi_n;
            acc_lo <= (state == ST_MUL) ? mul_lo_n : div_lo_n;
            cnt    <= cnt + CNT_W'(1);
            if (cnt == LAST_CNT) begin
              // Last step: register the corrected result directly.
              state          <= ST_DONE;
              data_result    <= res_n;
              data_exception <= exc_n;
              data_resultRDY <= 1'b1;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy      = (state == ST_MUL) || (state == ST_DIV);
  assign state_dbg = state;

endmodule

// File: tb/tb_multdiv_seq.sv
module tb_multdiv_seq;

  localparam int W  = 32;
  localparam int EW = 32 + 1 + W;  // {start cycle, exception, result}

  logic         clock;
  logic         reset_n;
  logic [W-1:0] data_operandA;
  logic [W-1:0] data_operandB;
  logic         ctrl_MULT;
  logic         ctrl_DIV;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;
  logic [1:0]   state_dbg;

  multdiv_seq #(.WIDTH(W)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int            n_vec = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            rdy_cyc = 0;
  int            prev_rdy_cyc = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference model: plain signed 64-bit arithmetic.
  function automatic logic [W:0] model(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb;
    longint r;
    logic [63:0] ru;
    logic exc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (is_div && b == '0) return {1'b1, {W{1'b0}}};
    r  = is_div ? (sa / sb) : (sa * sb);
    ru = r;
    exc = (r != longint'($signed(ru[W-1:0])));
    return {exc, ru[W-1:0]};
  endfunction

  // Monitor: every RDY pulse must match the oldest live expectation and
  // arrive exactly W edges after its start edge.
  always @(posedge clock) begin
    #1;
    cyc = cyc + 1;
    if (data_resultRDY === 1'b1) begin
      prev_rdy_cyc = rdy_cyc;
      rdy_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("rdy_unexpected", 64'd1, 64'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check("result", 64'(data_result), 64'(exp_e[W-1:0]));
        check("exception", 64'(data_exception), 64'(exp_e[W]));
        check("latency", 64'(cyc - int'(exp_e[EW-1:W+1])), 64'(W));
        check("busy_at_rdy", 64'(busy), 64'd0);
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic start_op(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] er, input logic ee);
    exp_q.delete();  // anything in flight is aborted by this start
    exp_q.push_back({32'(cyc + 1), ee, er});
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = ~is_div;
    ctrl_DIV      = is_div;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom();
    data_operandB = $urandom();
  endtask

  task automatic start_model(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] m;
    m = model(is_div, a, b);
    start_op(is_div, a, b, m[W-1:0], m[W]);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clock);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      4: return W'(int'($urandom_range(0, 40)) - 20);
      default: return $urandom();
    endcase
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic         is_div;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         exc;
  } vec_t;

  vec_t tbl[14];
  int   busy_seen;

  initial begin
    tbl[0]  = '{1'b0, 32'h00000003, 32'hFFFFFFFB, 32'hFFFFFFF1, 1'b0};
    tbl[1]  = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
    tbl[2]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    tbl[3]  = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0};
    tbl[4]  = '{1'b1, 32'd100,      32'd7,        32'd14,       1'b0};
    tbl[5]  = '{1'b1, 32'd5,        32'd0,        32'd0,        1'b1};
    tbl[6]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    tbl[7]  = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000001, 1'b1};
    tbl[8]  = '{1'b0, 32'h80000000, 32'h00000001, 32'h80000000, 1'b0};
    tbl[9]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};
    tbl[10] = '{1'b1, 32'h80000000, 32'h00000001, 32'h80000000, 1'b0};
    tbl[11] = '{1'b1, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    tbl[12] = '{1'b1, 32'hFFFFFFFF, 32'h00000002, 32'h00000000, 1'b0};
    tbl[13] = '{1'b1, 32'h00000007, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0};

    reset_n = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    check("reset_result", 64'(data_result), 64'd0);
    check("reset_exception", 64'(data_exception), 64'd0);
    check("reset_rdy", 64'(data_resultRDY), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_state", 64'(state_dbg), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed vectors from the table.
    foreach (tbl[i]) begin
      start_op(tbl[i].is_div, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].exc);
      check("busy_after_start", 64'(busy), 64'd1);
      wait_drain("table_timeout");
    end

    // Reset in the middle of a multiply: outputs clear at once, no RDY later.
    start_op(1'b0, 32'd1234, 32'd5678, 32'd7006652, 1'b0);
    repeat (9) @(negedge clock);
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("midreset_result", 64'(data_result), 64'd0);
    check("midreset_exception", 64'(data_exception), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_state", 64'(state_dbg), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    busy_seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (busy) busy_seen++;
    end
    check("postreset_busy_cycles", 64'(busy_seen), 64'd0);
    check("postreset_result", 64'(data_result), 64'd0);

    // Both start strobes together in IDLE: ignored entirely.
    data_operandA = 32'd9;
    data_operandB = 32'd9;
    ctrl_MULT = 1'b1;
    ctrl_DIV  = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    busy_seen = 0;
    repeat (40) begin
      if (busy) busy_seen++;
      @(negedge clock);
    end
    check("both_busy_cycles", 64'(busy_seen), 64'd0);
    check("both_result", 64'(data_result), 64'd0);
    check("both_state", 64'(state_dbg), 64'd0);

    // Both strobes during an operation: it keeps running unchanged.
    start_model(1'b0, 32'hFFFF1234, 32'd77);
    repeat (5) @(negedge clock);
    ctrl_MULT = 1'b1;
    ctrl_DIV  = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    wait_drain("both_inflight_timeout");

    // Restart with a divide at cycle 20 of a multiply: one RDY, DIV result.
    start_model(1'b0, 32'd1000, 32'd1000);
    repeat (19) @(negedge clock);
    start_model(1'b1, 32'hFFFFFC18, 32'd7);
    wait_drain("restart_timeout");

    // Start in the DONE cycle: back-to-back RDY pulses W+1 edges apart.
    start_model(1'b0, 32'd3, 32'hFFFFFFFB);
    for (int i = 0; i < 60 && data_resultRDY !== 1'b1; i++) @(negedge clock);
    check("done_rdy_seen", 64'(data_resultRDY), 64'd1);
    start_model(1'b1, 32'd100, 32'd7);
    wait_drain("done_start_timeout");
    check("done_start_spacing", 64'(rdy_cyc - prev_rdy_cyc), 64'(W + 1));

    // Randomized operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      start_model(1'($urandom_range(0, 1)), pick(), pick());
      wait_drain("random_timeout");
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
